// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Time-shares one 5-bit ripple adder among NREQ requesters.
//   Round-robin grant, one operation in flight: IDLE -> EXEC -> DONE.
//   Operands are captured at grant. sum/cout are registered and returned
//   with a one-cycle done pulse tagged by done_id.
//   Optional feature macro: ADD_ARB_STATS_EN adds an 8-bit saturating
//   overflow counter output (ovf_count).
module adder_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] a_bus,
  input  logic [5*NREQ-1:0] b_bus,
  output logic [NREQ-1:0]   gnt,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [4:0]        sum,
  output logic              cout
`ifdef ADD_ARB_STATS_EN
  ,
  output logic [7:0]        ovf_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr, ptr_nxt;
  logic [IDW-1:0]   win_id, win_nxt;
  logic [4:0]       op_a, op_a_nxt;
  logic [4:0]       op_b, op_b_nxt;
  logic [NREQ-1:0]  gnt_nxt;
  logic             done_nxt;
  logic [IDW-1:0]   done_id_nxt;
  logic [4:0]       sum_nxt;
  logic             cout_nxt;

  logic             found;
  logic [IDW-1:0]   pick;
  logic [4:0]       add_sum;
  logic             add_cout;

  // Round-robin search: first asserted req starting at rr_ptr, wrapping mod NREQ.
  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : winner_scan
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  // The shared five-bit ripple-carry adder, carry-in tied to 0.
  always_comb begin : ripple_adder
    logic c;
    c       = 1'b0;
    add_sum = '0;
    for (int i = 0; i < 5; i++) begin
      add_sum[i] = op_a[i] ^ op_b[i] ^ c;
      c          = (op_a[i] & op_b[i]) | (c & (op_a[i] ^ op_b[i]));
    end
    add_cout = c;
  end

  // Next-state and next-output logic; everything defaults to hold.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = rr_ptr;
    win_nxt     = win_id;
    op_a_nxt    = op_a;
    op_b_nxt    = op_b;
    gnt_nxt     = gnt;
    done_nxt    = done;
    done_id_nxt = done_id;
    sum_nxt     = sum;
    cout_nxt    = cout;
    unique case (state)
      ST_IDLE: begin
        done_nxt = 1'b0;
        if (found) begin
          gnt_nxt   = NREQ'(1) << pick;
          op_a_nxt  = a_bus[5*int'(pick) +: 5];
          op_b_nxt  = b_bus[5*int'(pick) +: 5];
          win_nxt   = pick;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        sum_nxt     = add_sum;
        cout_nxt    = add_cout;
        done_id_nxt = win_id;
        done_nxt    = 1'b1;
        state_nxt   = ST_DONE;
      end
      ST_DONE: begin
        done_nxt  = 1'b0;
        gnt_nxt   = '0;
        ptr_nxt   = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; a reset aborts any op.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      win_id  <= '0;
      gnt     <= '0;
      done    <= 1'b0;
      done_id <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      // NOTE: the operand latches are reset as well; they are only ten
      // flops, and a clean reset value keeps the adder output deterministic.
      op_a    <= '0;
      op_b    <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= ptr_nxt;
      win_id  <= win_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      done_id <= done_id_nxt;
      sum     <= sum_nxt;
      cout    <= cout_nxt;
      op_a    <= op_a_nxt;
      op_b    <= op_b_nxt;
    end
  end

`ifdef ADD_ARB_STATS_EN
  // Saturating count of results that carried out of bit 4.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_count <= '0;
    end else if (state == ST_EXEC && add_cout && ovf_count != 8'hFF) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end
`endif

endmodule
